// File: rtl/lstm_state_mem_pkg.sv
// lstm_state_mem_pkg: shared types, mode constants and defaults for the LSTM state memory
package lstm_state_mem_pkg;
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;
   localparam int WR_OLD       = 0;
   localparam int WR_NEW       = 1;
   localparam int DEF_WIDTH    = 32;
   localparam int DEF_NUM      = 53;
   localparam int DEF_TIMESTEP = 4;
   function automatic int phys(input int ts, input int idx, input int num);
      return ts * num + idx;
   endfunction
endpackage

// File: rtl/lstm_state_mem_dp_ram.sv
// dp_ram: synchronous read-first RAM with one read/write port and one read-only port
module dp_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 212,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_a,
   input  logic             re_a,
   input  logic [AW-1:0]    addr_a,
   input  logic [WIDTH-1:0] wd_a,
   output logic [WIDTH-1:0] q_a,
   input  logic             re_b,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] q_b
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
   always_comb begin
      q_a_d = re_a ? mem[addr_a] : q_a_q;
      q_b_d = re_b ? mem[addr_b] : q_b_q;
   end
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wd_a;
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
   end
   assign q_a = q_a_q;
   assign q_b = q_b_q;
endmodule

// File: rtl/lstm_state_mem.sv
// lstm_state_mem: timestep-banked dual-port state memory with zero-fill, collision bypass and range checking
module lstm_state_mem
   import lstm_state_mem_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NUM        = DEF_NUM,
   parameter int TIMESTEP   = DEF_TIMESTEP,
   parameter int ADDR_W     = 12,
   parameter int TS_W       = 4,
   parameter int WR_FIRST   = WR_OLD,
   parameter int CLR_ON_RST = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    step,
   input  logic                    wr_a,
   input  logic                    rd_a,
   input  logic [ADDR_W-1:0]       addr_a,
   input  logic [WIDTH-1:0]        i_a,
   input  logic                    rd_b,
   input  logic [TS_W-1:0]         ts_b,
   input  logic [ADDR_W-1:0]       addr_b,
   output logic signed [WIDTH-1:0] o_a,
   output logic                    o_a_vld,
   output logic signed [WIDTH-1:0] o_b,
   output logic                    o_b_vld,
   output logic [TS_W-1:0]         cur_ts,
   output logic                    wrap,
   output logic                    busy,
   output logic                    err
);
   localparam int DEPTH     = NUM * TIMESTEP;
   localparam int AW        = $clog2(DEPTH);
   localparam bit NEW_FIRST = WR_FIRST == WR_NEW;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             init_q, init_d;
   logic [TS_W-1:0]  cur_ts_q, cur_ts_d;
   logic             wrap_q, wrap_d, err_q, err_d;
   logic             a_vld_q, a_vld_d, b_vld_q, b_vld_d;
   logic             a_ram_q, a_ram_d, b_ram_q, b_ram_d;
   logic [WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
   logic [WIDTH-1:0] ram_q_a, ram_q_b, ram_wd;
   logic [AW-1:0]    pa_a, pa_b, ram_addr_a;
   logic             busy_w, a_oor, b_oor, wr_ok, rd_a_ok, rd_b_ok, coll_b;
   logic             ram_we, ram_re_a, ram_re_b;

   assign pa_a  = AW'(phys(int'(cur_ts_q), int'(addr_a), NUM));
   assign pa_b  = AW'(phys(int'(ts_b), int'(addr_b), NUM));
   assign a_oor = int'(addr_a) >= NUM;
   assign b_oor = int'(addr_b) >= NUM || int'(ts_b) >= TIMESTEP;

   // Output process: access qualification and RAM port control
   always_comb begin
      busy_w     = state_q == CLEAR;
      wr_ok      = rst && wr_a && !busy_w && !a_oor;
      rd_a_ok    = rst && rd_a && !busy_w;
      rd_b_ok    = rst && rd_b && !busy_w;
      coll_b     = wr_ok && !b_oor && pa_b == pa_a;
      ram_we     = (rst && busy_w) || wr_ok;
      ram_addr_a = busy_w ? cnt_q : pa_a;
      ram_wd     = busy_w ? '0 : i_a;
      ram_re_a   = rd_a_ok && !a_oor;
      ram_re_b   = rd_b_ok && !b_oor;
   end

   // Next-state process: fill sequencer and timestep pointer
   always_comb begin
      state_d  = busy_w ? (cnt_q == AW'(DEPTH - 1) ? IDLE : CLEAR)
                        : ((clr || init_q) ? CLEAR : IDLE);
      cnt_d    = busy_w ? cnt_q + AW'(1) : '0;
      init_d   = 1'b0;
      cur_ts_d = step ? (cur_ts_q == TS_W'(TIMESTEP - 1) ? '0 : cur_ts_q + TS_W'(1)) : cur_ts_q;
      wrap_d   = step && cur_ts_q == TS_W'(TIMESTEP - 1);
      err_d    = (clr && !busy_w) ? 1'b0
               : err_q | (!busy_w && ((a_oor && (wr_a || rd_a)) || (b_oor && rd_b)));
   end

   // Read result selection; a same-cycle write bypasses the RAM only in new-data mode
   always_comb begin
      a_vld_d  = rd_a_ok;
      b_vld_d  = rd_b_ok;
      a_ram_d  = rd_a_ok ? !a_oor && !(NEW_FIRST && wr_ok) : a_ram_q;
      b_ram_d  = rd_b_ok ? !b_oor && !(NEW_FIRST && coll_b) : b_ram_q;
      a_hold_d = rd_a_ok ? (a_oor ? '0 : i_a) : a_hold_q;
      b_hold_d = rd_b_ok ? (b_oor ? '0 : i_a) : b_hold_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         init_q   <= CLR_ON_RST != 0;
         cur_ts_q <= '0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         a_vld_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         a_ram_q  <= 1'b0;
         b_ram_q  <= 1'b0;
         a_hold_q <= '0;
         b_hold_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         init_q   <= init_d;
         cur_ts_q <= cur_ts_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
         a_vld_q  <= a_vld_d;
         b_vld_q  <= b_vld_d;
         a_ram_q  <= a_ram_d;
         b_ram_q  <= b_ram_d;
         a_hold_q <= a_hold_d;
         b_hold_q <= b_hold_d;
      end
   end

   dp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk    (clk),
      .we_a   (ram_we),
      .re_a   (ram_re_a),
      .addr_a (ram_addr_a),
      .wd_a   (ram_wd),
      .q_a    (ram_q_a),
      .re_b   (ram_re_b),
      .addr_b (pa_b),
      .q_b    (ram_q_b)
   );

   assign o_a     = a_ram_q ? ram_q_a : a_hold_q;
   assign o_b     = b_ram_q ? ram_q_b : b_hold_q;
   assign o_a_vld = a_vld_q;
   assign o_b_vld = b_vld_q;
   assign cur_ts  = cur_ts_q;
   assign wrap    = wrap_q;
   assign busy    = busy_w;
   assign err     = err_q;
endmodule

// File: tb/tb_lstm_state_mem.sv
// tb_lstm_state_mem: vector table, corner sequences and random traffic against a memory model, old-data and new-data instances
module tb_lstm_state_mem;
   logic clk = 1'b0;
   logic rst, clr, step, wr_a, rd_a, rd_b;
   logic [11:0] addr_a, addr_b;
   logic [31:0] i_a;
   logic [3:0] ts_b;
   logic signed [31:0] o_a0, o_b0, o_a1, o_b1;
   logic o_a_vld0, o_b_vld0, wrap0, busy0, err0;
   logic o_a_vld1, o_b_vld1, wrap1, busy1, err1;
   logic [3:0] cur_ts0, cur_ts1;

   always #5 clk = ~clk;

   lstm_state_mem u0 (
      .clk(clk), .rst(rst), .clr(clr), .step(step), .wr_a(wr_a), .rd_a(rd_a),
      .addr_a(addr_a), .i_a(i_a), .rd_b(rd_b), .ts_b(ts_b), .addr_b(addr_b),
      .o_a(o_a0), .o_a_vld(o_a_vld0), .o_b(o_b0), .o_b_vld(o_b_vld0),
      .cur_ts(cur_ts0), .wrap(wrap0), .busy(busy0), .err(err0)
   );

   lstm_state_mem #(.WR_FIRST(1)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .step(step), .wr_a(wr_a), .rd_a(rd_a),
      .addr_a(addr_a), .i_a(i_a), .rd_b(rd_b), .ts_b(ts_b), .addr_b(addr_b),
      .o_a(o_a1), .o_a_vld(o_a_vld1), .o_b(o_b1), .o_b_vld(o_b_vld1),
      .cur_ts(cur_ts1), .wrap(wrap1), .busy(busy1), .err(err1)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Behavioural model: flat word array, clear countdown, per-mode read results
   logic [31:0] mem_m [212];
   int m_ts, m_left, m_pend;
   logic [31:0] m_oa [2];
   logic [31:0] m_ob [2];
   bit m_oav, m_obv, m_wrap, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      bit busy = m_left > 0;
      bit aoor = addr_a >= 12'd53;
      bit boor = addr_b >= 12'd53 || ts_b >= 4'd4;
      int pa = m_ts * 53 + int'(addr_a);
      int pb = int'(ts_b) * 53 + int'(addr_b);
      bit wr = wr_a && !busy && !aoor;
      if (!rst) begin
         m_ts = 0; m_wrap = 0; m_err = 0; m_oav = 0; m_obv = 0;
         m_oa = '{0, 0}; m_ob = '{0, 0}; m_left = 0; m_pend = 1;
      end else begin
         m_oav = rd_a && !busy;
         m_obv = rd_b && !busy;
         for (int k = 0; k < 2; k++) begin
            if (m_oav) m_oa[k] = aoor ? 32'h0 : (k == 1 && wr) ? i_a : mem_m[pa];
            if (m_obv) m_ob[k] = boor ? 32'h0 : (k == 1 && wr && pb == pa) ? i_a : mem_m[pb];
         end
         if (clr && !busy) m_err = 0;
         else if (!busy && (((rd_a || wr_a) && aoor) || (rd_b && boor))) m_err = 1;
         if (wr) mem_m[pa] = i_a;
         if (busy) begin
            mem_m[212 - m_left] = 0;
            m_left--;
         end else if (clr || m_pend != 0) m_left = 212;
         m_pend = 0;
         m_wrap = step && m_ts == 3;
         if (step) m_ts = (m_ts + 1) % 4;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("oa0", o_a0, m_oa[0]);      chk("oa1", o_a1, m_oa[1]);
      chk("oav0", o_a_vld0, m_oav);   chk("oav1", o_a_vld1, m_oav);
      chk("ob0", o_b0, m_ob[0]);      chk("ob1", o_b1, m_ob[1]);
      chk("obv0", o_b_vld0, m_obv);   chk("obv1", o_b_vld1, m_obv);
      chk("ts0", cur_ts0, 32'(m_ts)); chk("ts1", cur_ts1, 32'(m_ts));
      chk("wrap0", wrap0, m_wrap);    chk("wrap1", wrap1, m_wrap);
      chk("busy0", busy0, m_left > 0); chk("busy1", busy1, m_left > 0);
      chk("err0", err0, m_err);       chk("err1", err1, m_err);
   endtask

   task automatic idle_in();
      clr = 0; step = 0; wr_a = 0; rd_a = 0; rd_b = 0;
      addr_a = 0; addr_b = 0; i_a = 0; ts_b = 0;
   endtask

   task automatic run_clear(output int n);
      n = busy0 ? 1 : 0;
      while (busy0 && n < 300) begin
         tick();
         if (busy0) n++;
      end
   endtask

   typedef struct {
      logic wr; logic [31:0] d; int aa; logic rda; logic rdb; int tb; int ab; logic st;
      logic [31:0] oa0; logic [31:0] oa1; logic oav;
      logic [31:0] ob0; logic [31:0] ob1; logic obv; int ts; logic wrp;
   } vec_t;
   vec_t tbl [14];

   initial begin
      int n;
      tbl[0]  = '{0, 32'h00, 0, 0, 1, 3, 52, 0, 32'h00, 32'h00, 0, 32'h00, 32'h00, 1, 0, 0};
      tbl[1]  = '{1, 32'hA5, 7, 0, 0, 0, 0,  0, 32'h00, 32'h00, 0, 32'h00, 32'h00, 0, 0, 0};
      tbl[2]  = '{0, 32'h00, 0, 0, 1, 0, 7,  0, 32'h00, 32'h00, 0, 32'hA5, 32'hA5, 1, 0, 0};
      tbl[3]  = '{1, 32'h22, 9, 0, 0, 0, 0,  0, 32'h00, 32'h00, 0, 32'hA5, 32'hA5, 0, 0, 0};
      tbl[4]  = '{1, 32'h11, 9, 0, 1, 0, 9,  0, 32'h00, 32'h00, 0, 32'h22, 32'h11, 1, 0, 0};
      tbl[5]  = '{0, 32'h00, 9, 1, 0, 0, 0,  0, 32'h11, 32'h11, 1, 32'h22, 32'h11, 0, 0, 0};
      tbl[6]  = '{1, 32'h33, 9, 1, 0, 0, 0,  0, 32'h11, 32'h33, 1, 32'h22, 32'h11, 0, 0, 0};
      tbl[7]  = '{0, 32'h00, 0, 0, 0, 0, 0,  1, 32'h11, 32'h33, 0, 32'h22, 32'h11, 0, 1, 0};
      tbl[8]  = '{1, 32'h44, 5, 0, 0, 0, 0,  1, 32'h11, 32'h33, 0, 32'h22, 32'h11, 0, 2, 0};
      tbl[9]  = '{0, 32'h00, 0, 0, 1, 1, 5,  0, 32'h11, 32'h33, 0, 32'h44, 32'h44, 1, 2, 0};
      tbl[10] = '{0, 32'h00, 0, 0, 0, 0, 0,  1, 32'h11, 32'h33, 0, 32'h44, 32'h44, 0, 3, 0};
      tbl[11] = '{0, 32'h00, 0, 0, 0, 0, 0,  1, 32'h11, 32'h33, 0, 32'h44, 32'h44, 0, 0, 1};
      tbl[12] = '{0, 32'h00, 0, 0, 0, 0, 0,  0, 32'h11, 32'h33, 0, 32'h44, 32'h44, 0, 0, 0};
      tbl[13] = '{0, 32'h00, 7, 1, 0, 0, 0,  0, 32'hA5, 32'hA5, 1, 32'h44, 32'h44, 0, 0, 0};

      idle_in();
      rst = 0;
      tick();
      tick();
      // V1: zero-fill after reset release
      rst = 1;
      tick();
      chk("v1_busy_first", busy0, 1);
      run_clear(n);
      chk("v1_busy_cycles", 32'(n), 212);

      // V2-V4 as vector table
      for (int r = 0; r < 14; r++) begin
         wr_a = tbl[r].wr; i_a = tbl[r].d; addr_a = 12'(tbl[r].aa); rd_a = tbl[r].rda;
         rd_b = tbl[r].rdb; ts_b = 4'(tbl[r].tb); addr_b = 12'(tbl[r].ab); step = tbl[r].st;
         tick();
         chk($sformatf("t%0d_oa0", r), o_a0, tbl[r].oa0);
         chk($sformatf("t%0d_oa1", r), o_a1, tbl[r].oa1);
         chk($sformatf("t%0d_oav", r), o_a_vld0, tbl[r].oav);
         chk($sformatf("t%0d_ob0", r), o_b0, tbl[r].ob0);
         chk($sformatf("t%0d_ob1", r), o_b1, tbl[r].ob1);
         chk($sformatf("t%0d_obv", r), o_b_vld0, tbl[r].obv);
         chk($sformatf("t%0d_ts", r), cur_ts0, 32'(tbl[r].ts));
         chk($sformatf("t%0d_wrap", r), wrap0, tbl[r].wrp);
      end
      idle_in();

      // V5: out-of-range read, sticky err, clr, write dropped mid-clear
      rd_a = 1; addr_a = 12'd53;
      tick();
      chk("v5_oa", o_a0, 0); chk("v5_oav", o_a_vld0, 1); chk("v5_err", err0, 1);
      idle_in();
      tick();
      tick();
      chk("v5_err_held", err0, 1);
      clr = 1;
      tick();
      clr = 0;
      chk("v5_err_clr", err0, 0); chk("v5_busy", busy0, 1);
      repeat (50) tick();
      wr_a = 1; addr_a = 12'd3; i_a = 32'hDEAD;
      tick();
      idle_in();
      run_clear(n);
      chk("v5_clear_done", busy0, 0);
      rd_a = 1; addr_a = 12'd3;
      tick();
      chk("v5_dropped_wr", o_a0, 0); chk("v5_dropped_vld", o_a_vld0, 1);
      idle_in();

      // V6: reset mid-clear aborts, restart covers the whole depth
      step = 1;
      tick();
      tick();
      idle_in();
      wr_a = 1; addr_a = 12'd44; i_a = 32'h150;
      tick();
      idle_in();
      rd_a = 1; addr_a = 12'd44;
      tick();
      chk("v6_pre_oa", o_a0, 32'h150);
      idle_in();
      clr = 1;
      tick();
      clr = 0;
      repeat (9) tick();
      step = 1;
      tick();
      step = 0;
      repeat (89) tick();
      rst = 0;
      tick();
      chk("v6_oa", o_a0, 0); chk("v6_ob", o_b0, 0); chk("v6_oav", o_a_vld0, 0);
      chk("v6_obv", o_b_vld0, 0); chk("v6_ts", cur_ts0, 0); chk("v6_wrap", wrap0, 0);
      chk("v6_busy", busy0, 0); chk("v6_err", err0, 0);
      rst = 1;
      tick();
      run_clear(n);
      chk("v6_restart_cycles", 32'(n), 212);
      rd_b = 1; ts_b = 4'd2; addr_b = 12'd44;
      tick();
      chk("v6_cleared", o_b0, 0); chk("v6_cleared_vld", o_b_vld0, 1);
      idle_in();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst    = $urandom_range(0, 399) != 0;
         clr    = $urandom_range(0, 99) == 0;
         step   = $urandom_range(0, 7) == 0;
         wr_a   = $urandom_range(0, 1) == 1;
         rd_a   = $urandom_range(0, 1) == 1;
         rd_b   = $urandom_range(0, 1) == 1;
         addr_a = 12'($urandom_range(0, 56));
         i_a    = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ts_b = 4'(m_ts); addr_b = addr_a;
         end else begin
            ts_b = 4'($urandom_range(0, 4)); addr_b = 12'($urandom_range(0, 56));
         end
         tick();
      end
      idle_in();
      rst = 1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lstm_state_mem.md
LSTM_STATE_MEM -- requirements
Module: lstm_state_mem

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- WIDTH, 32, data word width.
- NUM, 53, words per timestep.
- TIMESTEP, 4, timestep slots; depth = NUM*TIMESTEP.
- ADDR_W, 12, index width for addr_a/addr_b.
- TS_W, 4, timestep index width.
- WR_FIRST, 0, read-during-write mode: 0 = old data, 1 = new data.
- CLR_ON_RST, 1, 1 = zero-fill all words after reset.

REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-low reset.
- clr, in, 1, pulse that starts a zero-fill.
- step, in, 1, pulse that advances the current timestep pointer.
- wr_a, in, 1, port A write enable.
- rd_a, in, 1, port A read strobe.
- addr_a, in, ADDR_W, port A index within the current timestep.
- i_a, in, WIDTH, port A write data.
- rd_b, in, 1, port B read strobe.
- ts_b, in, TS_W, port B timestep.
- addr_b, in, ADDR_W, port B index.
- o_a, out, WIDTH signed, port A read data.
- o_a_vld, out, 1, o_a valid.
- o_b, out, WIDTH signed, port B read data.
- o_b_vld, out, 1, o_b valid.
- cur_ts, out, TS_W, current timestep pointer.
- wrap, out, 1, one-cycle pulse when cur_ts wraps.
- busy, out, 1, zero-fill in progress.
- err, out, 1, sticky out-of-range access flag.

Function
REQ-003 Physical address SHALL be ts*NUM+index: ts = cur_ts for port A, ts = ts_b for port B.
REQ-004 wr_a SHALL write i_a at the clock edge; write latency is 1 cycle.
REQ-005 rd_a or rd_b SHALL produce data and a valid of 1 on the next edge; valids SHALL be 0 when no strobe is given; o_a/o_b SHALL hold their last value otherwise.
REQ-006 Port A read and write to the same address in the same cycle: o_a SHALL be old data if WR_FIRST=0, i_a if WR_FIRST=1.
REQ-007 Port B read of the address port A writes in the same cycle SHALL follow the same WR_FIRST rule.
REQ-008 step SHALL increment cur_ts. From TIMESTEP-1, cur_ts SHALL go to 0 and wrap SHALL pulse for one cycle.
REQ-009 step coincident with wr_a SHALL write into the pre-increment timestep.
REQ-010 FSM SHALL have states IDLE and CLEAR.
- IDLE->CLEAR on clr, or on reset release when CLR_ON_RST=1.
- CLEAR writes 0 to one address per cycle, ascending from 0 to NUM*TIMESTEP-1, then returns to IDLE.
- Clear duration SHALL be exactly NUM*TIMESTEP cycles.
REQ-011 While busy=1: wr_a SHALL be dropped, rd_a/rd_b SHALL return valid=0, step SHALL be honoured, and clr SHALL be ignored.
REQ-012 addr >= NUM or ts_b >= TIMESTEP: a write SHALL be dropped, a read SHALL return 0 with valid=1, and err SHALL set.
REQ-013 err SHALL clear only on reset or clr.

Reset
REQ-014 With rst=0 at the edge: o_a=0, o_b=0, both valids=0, cur_ts=0, wrap=0, err=0, and the FSM goes to IDLE.
REQ-015 busy SHALL be 1 on the first cycle after release when CLR_ON_RST=1.
REQ-016 Memory contents SHALL be unaffected by reset except through the zero-fill.
REQ-017 Reset during CLEAR SHALL abort the fill; the fill restarts from address 0 on release if CLR_ON_RST=1.

Structure
REQ-018 Shared package SHALL hold: FSM state encodings, WR_FIRST mode constants, default WIDTH/NUM/TIMESTEP.
REQ-019 Storage SHALL be one sub-module dp_ram, with one read/write port and one read-only port, parametrised in WIDTH and depth.
REQ-020 Address arithmetic, collision bypass, FSM and pointer logic SHALL live in lstm_state_mem.

Verification
REQ-021 Benches SHALL cover these scenarios:
- V1: CLR_ON_RST=1, release rst -> busy=1 for exactly 4*53=212 cycles; then rd_b of ts_b=3, addr_b=52 returns 0 with o_b_vld=1.
- V2: wr_a i_a=0x0000_00A5, addr_a=7, cur_ts=0; next cycle rd_b ts_b=0, addr_b=7 -> o_b=0xA5 one cycle later.
- V3: same-cycle wr_a 0x11 and rd_b at the same address, after prior content 0x22 -> o_b=0x22 (WR_FIRST=0), o_b=0x11 (WR_FIRST=1).
- V4: 4 step pulses from cur_ts=0 -> cur_ts sequence 1,2,3,0, wrap pulses only on the 3->0 edge; a write with step at cur_ts=1 lands at address 53+addr_a.
- V5: rd_a with addr_a=53 -> o_a=0, o_a_vld=1, err=1 held; clr clears err; a wr_a issued mid-clear is not stored (reads 0 afterwards).
- V6: assert rst low at clear cycle 100 -> all outputs 0 next cycle; the fill restarts from address 0 after release.
